jtim: RTL
=========

# jtim

Dual-channel 16-bit interval timer that responds to one JRC I/O select strobe. It sits on the device side of the glue-logic bus. It decodes the active-low chip select and the PHI2-qualified read/write strobes, and serves register reads and writes over the 8-bit data bus. It raises an active-low interrupt when an enabled channel underflows.

## Interface
Parameters:
- RESET_PRESCALE, 8'h00, prescaler register value after reset.

Ports:
- PHI2, in, 1, the only clock. All state updates on the falling edge.
- RESET, in, 1, asynchronous, active-high.
- nCS, in, 1, active-low device select, driven by an nIOxSEL line.
- nRD, in, 1, active-low read strobe, already qualified by PHI2 high.
- nWR, in, 1, active-low write strobe, already qualified by PHI2 high.
- A, in, 4, register address (CPU A3..A0).
- D_IN, in, 8, write data.
- D_OUT, out, 8, read data. 8'h00 when not reading.
- D_OE, out, 1, data bus drive enable.
- nIRQ, out, 1, active-low interrupt request, level.

## Operation
- Register map (A):
  - 0: CH0 reload low (W); CH0 count low (R).
  - 1: CH0 reload high (W); CH0 snapshot high (R).
  - 4/5: same pair for CH1.
  - 8: CTRL. Bit0 CH0 enable, bit1 CH0 continuous, bit2 CH1 enable, bit3 CH1 continuous.
  - 9: STATUS. Bit0 CH0 underflow, bit1 CH1 underflow. Write 1 to clear.
  - 10: IRQEN, bits 1:0.
  - 11: PRESCALE.
  - All other addresses read 8'h00; writes to them are ignored.
  - Unused bits read 0.
- Read (nCS=0, nRD=0):
  - D_OE=1; D_OUT is combinational from the current register state.
  - Reading a count-low register also captures that channel's count[15:8] into its snapshot register at the falling edge.
- Write (nCS=0, nWR=0): register updated at the falling edge from D_IN.
  - Writing reload high loads count <= {D_IN, reload_low} at the same edge.
- Prescaler:
  - 8-bit down-counter shared by both channels.
  - Produces tick every PRESCALE+1 PHI2 cycles; reloads PRESCALE on tick.
  - Writing PRESCALE reloads the prescaler counter immediately.
- Channel, on tick while enabled:
  - count != 0: count decrements.
  - count == 0: underflow. STATUS bit is set. Continuous mode reloads count from reload. One-shot mode clears its CTRL enable bit and holds count at 0.
  - Continuous with reload 0 underflows on every tick.
- A disabled channel holds its count.
- nIRQ = ~|(STATUS[1:0] & IRQEN[1:0]).

## Timing
- Reset values: counts, reloads, snapshots, CTRL, STATUS and IRQEN are 0; PRESCALE = RESET_PRESCALE; prescaler counter = RESET_PRESCALE; nIRQ=1; D_OE=0; D_OUT=8'h00.
- Read data is combinational: valid while nRD is low, from pre-edge state.
- Write effect is visible on the cycle after the falling edge.
- nIRQ asserts in the same PHI2 cycle as the STATUS bit sets (combinational from registers).
- Simultaneous events at one edge:
  - STATUS W1C and underflow on the same bit: set wins.
  - Reload-high write and underflow on the same channel: the write wins and no STATUS set occurs.
  - CTRL write and one-shot auto-clear: the written value wins.
  - Count-low read during a decrement: returns the pre-edge value, and the snapshot captures the pre-edge high byte.
- RESET asserted mid-operation clears everything immediately, independent of PHI2.
- nRD and nWR both low with nCS low is illegal: the write is performed and D_OE stays 1.

## Structure
- Shared package jtim_pkg holds:
  - register address constants;
  - CTRL bit positions;
  - a channel state struct (count, reload, snapshot).
- Sub-module jtim_channel is instantiated twice. It owns the 16-bit count, reload and snapshot. Its inputs are tick, enable, mode, write strobes and data; its outputs are count, underflow and one-shot clear.
- Top level owns:
  - address decode;
  - CTRL, STATUS, IRQEN and the prescaler;
  - the read mux.

## Test plan
- Reset: assert RESET mid-count → nIRQ=1, all registers read 0, PRESCALE reads RESET_PRESCALE.
- One-shot CH0:
  - Stimulus: PRESCALE=0, reload=0x0003, CTRL=0x01.
  - After 4 PHI2 falling edges: STATUS=0x01, CTRL bit0=0, count stays 0.
  - With IRQEN=0x01, nIRQ=0 until STATUS is written 0x01.
- Continuous CH1:
  - Stimulus: PRESCALE=3, reload=0x0001, CTRL=0x0C.
  - Required: underflow every 8 PHI2 cycles, count reloads to 1.
- Snapshot:
  - Stimulus: reload=0x0100, running; read count low exactly as count goes 0x0100→0x00FF.
  - Required: read returns 0x00 and snapshot high returns 0x01.
- Collision:
  - W1C of STATUS bit0 on the underflow edge → bit stays 1.
  - Reload-high write on the underflow edge → count = new reload, no STATUS set.
- Bus: a read from address 0xF returns D_OUT=0x00 with D_OE=1; nCS=1 gives D_OE=0 for any nRD/nWR.

Source files
------------

// File: rtl/jtim_pkg.sv
// Shared definitions for the jtim dual-channel interval timer:
// register map, CTRL bit positions and per-channel register state.
package jtim_pkg;

  localparam logic [3:0] A_CH0_LO   = 4'h0;
  localparam logic [3:0] A_CH0_HI   = 4'h1;
  localparam logic [3:0] A_CH1_LO   = 4'h4;
  localparam logic [3:0] A_CH1_HI   = 4'h5;
  localparam logic [3:0] A_CTRL     = 4'h8;
  localparam logic [3:0] A_STATUS   = 4'h9;
  localparam logic [3:0] A_IRQEN    = 4'hA;
  localparam logic [3:0] A_PRESCALE = 4'hB;

  localparam int unsigned CTRL_CH0_EN   = 0;
  localparam int unsigned CTRL_CH0_CONT = 1;
  localparam int unsigned CTRL_CH1_EN   = 2;
  localparam int unsigned CTRL_CH1_CONT = 3;

  typedef struct packed {
    logic [15:0] count;
    logic [15:0] reload;
    logic [7:0]  snapshot;
  } chan_state_t;

endpackage

// File: rtl/jtim_channel.sv
// One 16-bit timer channel: count/reload/snapshot registers, decrement on
// prescaler tick, underflow detection with continuous or one-shot behaviour.
module jtim_channel
  import jtim_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        en_i,
  input  logic        cont_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic        rd_lo_i,
  input  logic [7:0]  data_i,
  output logic [15:0] count_o,
  output logic [7:0]  snapshot_o,
  output logic        underflow_o,
  output logic        oneshot_clr_o
);

  chan_state_t st_q, st_d;
  logic        underflow;

  // A reload-high write on the underflow edge overrides the underflow entirely.
  assign underflow = tick_i & en_i & (st_q.count == '0) & ~wr_hi_i;

  always_comb begin
    st_d = st_q;
    if (wr_lo_i) st_d.reload[7:0] = data_i;
    if (wr_hi_i) begin
      st_d.reload[15:8] = data_i;
      st_d.count        = {data_i, st_q.reload[7:0]};
    end else if (tick_i && en_i) begin
      if (st_q.count != '0) st_d.count = st_q.count - 16'd1;
      else if (cont_i)      st_d.count = st_q.reload;
    end
    if (rd_lo_i) st_d.snapshot = st_q.count[15:8];
  end

  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) st_q <= '0;
    else       st_q <= st_d;
  end

  assign count_o       = st_q.count;
  assign snapshot_o    = st_q.snapshot;
  assign underflow_o   = underflow;
  assign oneshot_clr_o = underflow & ~cont_i;

endmodule

// File: rtl/jtim.sv
// jtim top: bus decode, CTRL/STATUS/IRQEN/PRESCALE registers, shared
// prescaler, read mux and the two timer channels. State changes on PHI2 fall.
module jtim
  import jtim_pkg::*;
#(
  parameter logic [7:0] RESET_PRESCALE = 8'h00
) (
  input  logic       PHI2,
  input  logic       RESET,
  input  logic       nCS,
  input  logic       nRD,
  input  logic       nWR,
  input  logic [3:0] A,
  input  logic [7:0] D_IN,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  output logic       nIRQ
);

  logic       rd, wr, tick;
  logic [3:0] ctrl_q, ctrl_d;
  logic [1:0] status_q, status_d, irqen_q, irqen_d, uf, clr;
  logic [7:0] prescale_q, prescale_d, pcnt_q, pcnt_d, rdata;
  logic [15:0] cnt0, cnt1;
  logic [7:0]  snap0, snap1;

  assign rd   = ~nCS & ~nRD;
  assign wr   = ~nCS & ~nWR;
  assign tick = (pcnt_q == '0);

  jtim_channel u_ch0 (
    .clk_i(PHI2), .rst_i(RESET), .tick_i(tick),
    .en_i(ctrl_q[CTRL_CH0_EN]), .cont_i(ctrl_q[CTRL_CH0_CONT]),
    .wr_lo_i(wr && (A == A_CH0_LO)), .wr_hi_i(wr && (A == A_CH0_HI)),
    .rd_lo_i(rd && (A == A_CH0_LO)), .data_i(D_IN),
    .count_o(cnt0), .snapshot_o(snap0), .underflow_o(uf[0]), .oneshot_clr_o(clr[0])
  );

  jtim_channel u_ch1 (
    .clk_i(PHI2), .rst_i(RESET), .tick_i(tick),
    .en_i(ctrl_q[CTRL_CH1_EN]), .cont_i(ctrl_q[CTRL_CH1_CONT]),
    .wr_lo_i(wr && (A == A_CH1_LO)), .wr_hi_i(wr && (A == A_CH1_HI)),
    .rd_lo_i(rd && (A == A_CH1_LO)), .data_i(D_IN),
    .count_o(cnt1), .snapshot_o(snap1), .underflow_o(uf[1]), .oneshot_clr_o(clr[1])
  );

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr && (A == A_CTRL)) begin
      ctrl_d = D_IN[3:0];
    end else begin
      if (clr[0]) ctrl_d[CTRL_CH0_EN] = 1'b0;
      if (clr[1]) ctrl_d[CTRL_CH1_EN] = 1'b0;
    end
    // W1C is applied before OR-ing in new underflows so a set wins.
    status_d = status_q;
    if (wr && (A == A_STATUS)) status_d = status_q & ~D_IN[1:0];
    status_d = status_d | uf;
    irqen_d = irqen_q;
    if (wr && (A == A_IRQEN)) irqen_d = D_IN[1:0];
    prescale_d = prescale_q;
    if (wr && (A == A_PRESCALE)) begin
      prescale_d = D_IN;
      pcnt_d     = D_IN;
    end else if (tick) begin
      pcnt_d = prescale_q;
    end else begin
      pcnt_d = pcnt_q - 8'd1;
    end
  end

  always_ff @(negedge PHI2 or posedge RESET) begin
    if (RESET) begin
      ctrl_q     <= '0;
      status_q   <= '0;
      irqen_q    <= '0;
      prescale_q <= RESET_PRESCALE;
      pcnt_q     <= RESET_PRESCALE;
    end else begin
      ctrl_q     <= ctrl_d;
      status_q   <= status_d;
      irqen_q    <= irqen_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (A)
      A_CH0_LO:   rdata = cnt0[7:0];
      A_CH0_HI:   rdata = snap0;
      A_CH1_LO:   rdata = cnt1[7:0];
      A_CH1_HI:   rdata = snap1;
      A_CTRL:     rdata = {4'b0, ctrl_q};
      A_STATUS:   rdata = {6'b0, status_q};
      A_IRQEN:    rdata = {6'b0, irqen_q};
      A_PRESCALE: rdata = prescale_q;
      default:    rdata = '0;
    endcase
  end

  assign D_OE  = rd;
  assign D_OUT = rd ? rdata : '0;
  assign nIRQ  = ~|(status_q & irqen_q);

endmodule
